// File: rtl/pipeline_snapshot.sv
// Freezes N_CH pipeline latch vectors on a capture request and streams them out
// as a framed byte sequence (header, payload LSB-byte first, XOR checksum) over valid/ready.
module pipeline_snapshot #(
   parameter int         N_CH   = 4,
   parameter int         NB_CH  = 160,
   parameter logic [7:0] HEADER = 8'hA5
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_capture,
   input  logic [N_CH*NB_CH-1:0] i_data,
   input  logic                  i_ready,
   output logic [7:0]            o_data,
   output logic                  o_valid,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_dropped
);

   // state   | meaning
   // IDLE    | no frame; capture request loads snapshot
   // HEADER  | presenting frame start byte
   // PAYLOAD | presenting snapshot bytes, channel 0 first, LSB byte first
   // CHECK   | presenting XOR of all payload bytes

   localparam int NBYTES = (NB_CH + 7) / 8;
   localparam int TOTAL  = N_CH * NBYTES;
   localparam int IW     = $clog2(TOTAL + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD, ST_CHECK} state_t;

   state_t            state;
   logic [TOTAL*8-1:0] pad;
   logic [TOTAL*8-1:0] snap;
   logic [TOTAL*8-1:0] snap_shift;
   logic [IW-1:0]      idx;
   logic [7:0]         csum;
   logic               xfer;

   // Each channel occupies a whole number of bytes; bits above NB_CH stay zero.
   always_comb begin
      pad = '0;
      for (int k = 0; k < N_CH; k++) begin
         pad[k*NBYTES*8 +: NB_CH] = i_data[k*NB_CH +: NB_CH];
      end
   end

   assign snap_shift = snap >> 8;
   assign o_valid    = (state != ST_IDLE);
   assign o_busy     = (state != ST_IDLE);
   assign xfer       = o_valid & i_ready;

   // The snapshot shifts down one byte per accepted payload byte, so the
   // next byte to present is always in the low byte of snap_shift.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state     <= ST_IDLE;
         snap      <= '0;
         idx       <= '0;
         csum      <= '0;
         o_data    <= '0;
         o_done    <= 1'b0;
         o_dropped <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (i_capture && state != ST_IDLE) begin
            o_dropped <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (i_capture) begin
                  snap   <= pad;
                  csum   <= '0;
                  idx    <= '0;
                  o_data <= HEADER;
                  state  <= ST_HEADER;
               end
            end
            ST_HEADER: begin
               if (xfer) begin
                  o_data <= snap[7:0];
                  state  <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (xfer) begin
                  csum <= csum ^ o_data;
                  snap <= snap_shift;
                  idx  <= idx + IW'(1);
                  if (idx == LAST_IDX) begin
                     o_data <= csum ^ o_data;
                     state  <= ST_CHECK;
                  end else begin
                     o_data <= snap_shift[7:0];
                  end
               end
            end
            ST_CHECK: begin
               if (xfer) begin
                  o_data <= '0;
                  o_done <= 1'b1;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_snapshot.sv
// Directed bench for pipeline_snapshot: a 2x12-bit instance for framing corner
// cases and a default 4x160-bit instance for the full-size frame.
module tb_pipeline_snapshot;

   logic         clk_sys = 1'b0;
   logic         rst_b;

   logic         capture_a, ready_a;
   logic [23:0]  data_a;
   logic [7:0]   out_a;
   logic         valid_a, busy_a, done_a, dropped_a;

   logic         capture_b, ready_b;
   logic [639:0] data_b;
   logic [7:0]   out_b;
   logic         valid_b, busy_b, done_b, dropped_b;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_a [6];
   logic [7:0] byte_v;

   always #5 clk_sys = ~clk_sys;

   pipeline_snapshot #(.N_CH(2), .NB_CH(12), .HEADER(8'hA5)) dut_a (
      .i_clk(clk_sys), .i_reset(rst_b), .i_capture(capture_a), .i_data(data_a),
      .i_ready(ready_a), .o_data(out_a), .o_valid(valid_a), .o_busy(busy_a),
      .o_done(done_a), .o_dropped(dropped_a)
   );

   pipeline_snapshot dut_b (
      .i_clk(clk_sys), .i_reset(rst_b), .i_capture(capture_b), .i_data(data_b),
      .i_ready(ready_b), .o_data(out_b), .o_valid(valid_b), .o_busy(busy_b),
      .o_done(done_b), .o_dropped(dropped_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   // Checks bytes exp_a[first..5] on consecutive cycles with ready held high,
   // starting with the byte currently presented, then the done cycle.
   task automatic finish_frame_a(input int first);
      for (int i = first; i < 6; i++) begin
         check($sformatf("a_byte%0d", i), out_a, exp_a[i]);
         check($sformatf("a_valid%0d", i), valid_a, 1'b1);
         check($sformatf("a_done_early%0d", i), done_a, 1'b0);
         step();
      end
      check("a_done", done_a, 1'b1);
      check("a_busy_at_done", busy_a, 1'b0);
      check("a_valid_at_done", valid_a, 1'b0);
   endtask

   task automatic start_a();
      capture_a = 1'b1;
      step();
      capture_a = 1'b0;
   endtask

   initial begin
      exp_a[0] = 8'hA5; exp_a[1] = 8'hBC; exp_a[2] = 8'h0A;
      exp_a[3] = 8'h23; exp_a[4] = 8'h01; exp_a[5] = 8'h94;
      rst_b = 1'b0;
      capture_a = 1'b0; ready_a = 1'b1; data_a = {12'h123, 12'hABC};
      capture_b = 1'b0; ready_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
         byte_v = 8'(k + 1);
         data_b[k*160 +: 160] = {20{byte_v}};
      end
      step(); step();

      check("rst_valid", valid_a, 1'b0);
      check("rst_data", out_a, 8'h00);
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_dropped", dropped_a, 1'b0);
      check("rst_b_valid", valid_b, 1'b0);
      rst_b = 1'b1;
      step();

      // basic frame
      start_a();
      finish_frame_a(0);
      step();
      check("a_done_one_cycle", done_a, 1'b0);

      // backpressure while 0A is presented
      start_a();
      check("bp_hdr", out_a, 8'hA5);
      step();
      check("bp_bc", out_a, 8'hBC);
      step();
      ready_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp_hold_data%0d", i), out_a, 8'h0A);
         check($sformatf("bp_hold_valid%0d", i), valid_a, 1'b1);
         step();
      end
      ready_a = 1'b1;
      finish_frame_a(2);
      step();

      // snapshot immunity and dropped capture
      start_a();
      step();
      check("drop_bc", out_a, 8'hBC);
      data_a = '1;
      capture_a = 1'b1;
      step();
      capture_a = 1'b0;
      check("drop_flag", dropped_a, 1'b1);
      finish_frame_a(2);
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("drop_no_restart%0d", i), valid_a, 1'b0);
      end
      check("drop_sticky", dropped_a, 1'b1);
      data_a = {12'h123, 12'hABC};

      // reset mid-frame, asserted on the cycle byte 23 is accepted
      start_a();
      step(); step(); step();
      check("rst_mid_23", out_a, 8'h23);
      rst_b = 1'b0;
      step();
      rst_b = 1'b1;
      check("rst_mid_valid", valid_a, 1'b0);
      check("rst_mid_busy", busy_a, 1'b0);
      check("rst_mid_dropped", dropped_a, 1'b0);
      check("rst_mid_done", done_a, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("rst_mid_no_done%0d", i), done_a, 1'b0);
      end
      start_a();
      finish_frame_a(0);

      // back-to-back: capture during the done cycle
      capture_a = 1'b1;
      step();
      capture_a = 1'b0;
      check("b2b_dropped", dropped_a, 1'b0);
      finish_frame_a(0);
      check("b2b_dropped_end", dropped_a, 1'b0);
      step();

      // default-size frame
      capture_b = 1'b1;
      step();
      capture_b = 1'b0;
      check("def_hdr", out_b, 8'hA5);
      for (int i = 0; i < 80; i++) begin
         step();
         check($sformatf("def_byte%0d", i), out_b, 32'(i / 20 + 1));
         check($sformatf("def_valid%0d", i), valid_b, 1'b1);
      end
      step();
      check("def_csum", out_b, 8'h00);
      check("def_csum_valid", valid_b, 1'b1);
      step();
      check("def_done", done_b, 1'b1);
      check("def_busy", busy_b, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
